// File: rtl/flip_scheduler_if.sv
// Handshake/configuration bundle between run control, the flip scheduler
// and the flip engine.
//   master : run control / flip engine side (drives cfg, start, abort, spin events)
//   slave  : flip_scheduler (drives status, engine controls, issue gate)
interface flip_scheduler_if #(
  parameter int unsigned ICON_ADDR_W = 11,
  parameter int unsigned ITER_W      = 16
);
  logic                   cfg_valid_i;
  logic                   cfg_ready_o;
  logic [ICON_ADDR_W-1:0] cfg_icon_num_i;
  logic [ITER_W-1:0]      cfg_max_iter_i;
  logic                   cfg_flip_disable_i;
  logic                   start_i;
  logic                   abort_i;
  logic                   busy_o;
  logic                   done_o;
  logic [1:0]             stop_cause_o;
  logic [ITER_W-1:0]      iter_cnt_o;
  logic                   fe_en_o;
  logic                   fe_cmpt_en_o;
  logic                   fe_flush_o;
  logic                   fe_flip_disable_o;
  logic [ICON_ADDR_W-1:0] fe_icon_last_raddr_plus_one_o;
  logic                   fe_icon_finish_i;
  logic                   issue_allow_o;
  logic                   spin_issue_i;
  logic                   spin_retire_i;

  modport master (
    output cfg_valid_i, cfg_icon_num_i, cfg_max_iter_i, cfg_flip_disable_i,
           start_i, abort_i, fe_icon_finish_i, spin_issue_i, spin_retire_i,
    input  cfg_ready_o, busy_o, done_o, stop_cause_o, iter_cnt_o, fe_en_o,
           fe_cmpt_en_o, fe_flush_o, fe_flip_disable_o,
           fe_icon_last_raddr_plus_one_o, issue_allow_o
  );

  modport slave (
    input  cfg_valid_i, cfg_icon_num_i, cfg_max_iter_i, cfg_flip_disable_i,
           start_i, abort_i, fe_icon_finish_i, spin_issue_i, spin_retire_i,
    output cfg_ready_o, busy_o, done_o, stop_cause_o, iter_cnt_o, fe_en_o,
           fe_cmpt_en_o, fe_flush_o, fe_flip_disable_o,
           fe_icon_last_raddr_plus_one_o, issue_allow_o
  );
endinterface

// File: rtl/flip_scheduler.sv
// Run-level controller for the flip engine: loads a run configuration,
// flushes the engine, gates spin issue, stops on abort / iteration budget /
// icon exhaustion, drains in-flight spins and pulses done.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : flip_scheduler_if slave (cfg, start/abort, status,
//                  flip-engine controls, spin issue/retire events)
module flip_scheduler #(
  parameter int unsigned FLIP_ICON_DEPTH = 1024,
  parameter int unsigned ICON_ADDR_W     = $clog2(FLIP_ICON_DEPTH) + 1,
  parameter int unsigned ITER_W          = 16,
  parameter int unsigned MAX_INFLIGHT    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  flip_scheduler_if.slave bus
);
  localparam int unsigned OUT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned ITER_W1 = ITER_W + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_INFLIGHT);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_ICON   = 2'd1;
  localparam logic [1:0] CAUSE_BUDGET = 2'd2;
  localparam logic [1:0] CAUSE_ABORT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [ICON_ADDR_W-1:0] cfg_icon_num;
  logic [ITER_W-1:0]      cfg_max_iter;
  logic                   cfg_flip_disable;
  logic [OUT_W-1:0]       outstanding;
  logic [ITER_W-1:0]      iter_cnt;
  logic [1:0]             stop_cause, stop_cause_nxt;
  logic                   budget_hit, icon_hit;
  logic [1:0]             run_cause;
  logic                   cfg_ready, busy, done, fe_en, fe_cmpt_en, fe_flush, issue_allow;

  // Stop sources for the current RUN cycle; a retire this cycle counts toward the budget.
  always_comb begin
    budget_hit = (cfg_max_iter != '0) &&
                 (({1'b0, iter_cnt} + ITER_W1'(bus.spin_retire_i)) >= {1'b0, cfg_max_iter});
    icon_hit   = bus.fe_icon_finish_i & ~cfg_flip_disable;
    if (bus.abort_i)  run_cause = CAUSE_ABORT;
    else if (budget_hit) run_cause = CAUSE_BUDGET;
    else if (icon_hit)   run_cause = CAUSE_ICON;
    else                 run_cause = CAUSE_NONE;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt      = state;
    stop_cause_nxt = stop_cause;
    cfg_ready      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    fe_en          = 1'b0;
    fe_cmpt_en     = 1'b0;
    fe_flush       = 1'b0;
    issue_allow    = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        if (bus.start_i) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        fe_flush = 1'b1;
        fe_en    = 1'b1;
        // An abort during flush still lets the flush complete, then drains.
        stop_cause_nxt = bus.abort_i ? CAUSE_ABORT : CAUSE_NONE;
        state_nxt      = bus.abort_i ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        fe_en      = 1'b1;
        fe_cmpt_en = 1'b1;
        if (run_cause != CAUSE_NONE) begin
          stop_cause_nxt = run_cause;
          state_nxt      = S_DRAIN;
        end else begin
          issue_allow = (outstanding < OUT_MAX);
        end
      end
      S_DRAIN: begin
        fe_en = 1'b1;
        if ((outstanding == '0) && !bus.spin_retire_i) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration, counters and stop cause.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_icon_num     <= '0;
      cfg_max_iter     <= '0;
      cfg_flip_disable <= 1'b0;
      outstanding      <= '0;
      iter_cnt         <= '0;
      stop_cause       <= CAUSE_NONE;
    end else begin
      if (cfg_ready && bus.cfg_valid_i) begin
        cfg_icon_num     <= bus.cfg_icon_num_i;
        cfg_max_iter     <= bus.cfg_max_iter_i;
        cfg_flip_disable <= bus.cfg_flip_disable_i;
      end
      stop_cause <= stop_cause_nxt;
      if (state == S_FLUSH) begin
        outstanding <= '0;
        iter_cnt    <= '0;
      end else begin
        // Saturate on protocol errors rather than wrapping.
        if (bus.spin_issue_i && !bus.spin_retire_i && (outstanding != OUT_MAX))
          outstanding <= outstanding + OUT_W'(1);
        else if (bus.spin_retire_i && !bus.spin_issue_i && (outstanding != '0))
          outstanding <= outstanding - OUT_W'(1);
        if (((state == S_RUN) || (state == S_DRAIN)) && bus.spin_retire_i &&
            (iter_cnt != {ITER_W{1'b1}}))
          iter_cnt <= iter_cnt + ITER_W'(1);
      end
    end
  end

  // Protocol checks on the in-flight counter.
  a_no_issue_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.spin_issue_i && !bus.spin_retire_i && (outstanding == OUT_MAX)));
  a_no_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.spin_retire_i && !bus.spin_issue_i && (outstanding == '0)));

  assign bus.cfg_ready_o                   = cfg_ready;
  assign bus.busy_o                        = busy;
  assign bus.done_o                        = done;
  assign bus.stop_cause_o                  = stop_cause;
  assign bus.iter_cnt_o                    = iter_cnt;
  assign bus.fe_en_o                       = fe_en;
  assign bus.fe_cmpt_en_o                  = fe_cmpt_en;
  assign bus.fe_flush_o                    = fe_flush;
  assign bus.fe_flip_disable_o             = cfg_flip_disable;
  assign bus.fe_icon_last_raddr_plus_one_o = cfg_icon_num;
  assign bus.issue_allow_o                 = issue_allow;
endmodule

// File: tb/tb_flip_scheduler.sv
// Directed bench for flip_scheduler: reset, icon exhaustion, budget stop,
// backpressure, abort drain, simultaneous stops, config lockout, mid-run reset.
module tb_flip_scheduler;
  localparam int unsigned ICON_ADDR_W = 11;
  localparam int unsigned ITER_W      = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  flip_scheduler_if #(.ICON_ADDR_W(ICON_ADDR_W), .ITER_W(ITER_W)) bus();

  flip_scheduler #(
    .FLIP_ICON_DEPTH(1024),
    .ICON_ADDR_W    (ICON_ADDR_W),
    .ITER_W         (ITER_W),
    .MAX_INFLIGHT   (2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle spin/engine stimulus; cfg and start are dropped.
  task automatic drive(input logic issue, input logic retire, input logic finish, input logic abort);
    bus.cfg_valid_i      = 1'b0;
    bus.start_i          = 1'b0;
    bus.spin_issue_i     = issue;
    bus.spin_retire_i    = retire;
    bus.fe_icon_finish_i = finish;
    bus.abort_i          = abort;
    #1;
  endtask

  task automatic cfg_start(input logic valid, input logic start, input logic [ICON_ADDR_W-1:0] icon,
                           input logic [ITER_W-1:0] iter, input logic dis);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    bus.cfg_valid_i        = valid;
    bus.start_i            = start;
    bus.cfg_icon_num_i     = icon;
    bus.cfg_max_iter_i     = iter;
    bus.cfg_flip_disable_i = dis;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_icon_num_i = '0;
    bus.cfg_max_iter_i = '0;
    bus.cfg_flip_disable_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_cfg_ready", 32'(bus.cfg_ready_o), 1);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_allow", 32'(bus.issue_allow_o), 0);
    check("rst_fe_en", 32'(bus.fe_en_o), 0);
    check("rst_cause", 32'(bus.stop_cause_o), 0);
    check("rst_iter", 32'(bus.iter_cnt_o), 0);
    check("rst_icon_last", 32'(bus.fe_icon_last_raddr_plus_one_o), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Icon exhaustion: config and start in the same cycle.
    cfg_start(1'b1, 1'b1, 11'd4, 16'd0, 1'b0);
    tick();
    drive(0, 0, 0, 0);
    check("t1_flush", 32'(bus.fe_flush_o), 1);
    check("t1_flush_en", 32'(bus.fe_en_o), 1);
    check("t1_flush_allow", 32'(bus.issue_allow_o), 0);
    check("t1_flush_ready", 32'(bus.cfg_ready_o), 0);
    check("t1_icon_last", 32'(bus.fe_icon_last_raddr_plus_one_o), 4);
    tick();
    drive(1, 0, 0, 0);
    check("t1_run_allow", 32'(bus.issue_allow_o), 1);
    check("t1_run_cmpt", 32'(bus.fe_cmpt_en_o), 1);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(1, 1, 0, 0);
    check("t1_iter_c3", 32'(bus.iter_cnt_o), 2);
    tick(); drive(0, 0, 1, 0);
    check("t1_stop_allow", 32'(bus.issue_allow_o), 0);
    tick(); drive(0, 1, 0, 0);
    check("t1_drain_cmpt", 32'(bus.fe_cmpt_en_o), 0);
    check("t1_drain_en", 32'(bus.fe_en_o), 1);
    check("t1_cause", 32'(bus.stop_cause_o), 1);
    tick(); drive(0, 0, 0, 0);
    check("t1_drain_done", 32'(bus.done_o), 0);
    check("t1_iter", 32'(bus.iter_cnt_o), 4);
    tick(); drive(0, 0, 0, 0);
    check("t1_done", 32'(bus.done_o), 1);
    check("t1_done_en", 32'(bus.fe_en_o), 0);
    tick(); drive(0, 0, 0, 0);
    check("t1_done_pulse", 32'(bus.done_o), 0);
    check("t1_idle_busy", 32'(bus.busy_o), 0);
    check("t1_idle_iter", 32'(bus.iter_cnt_o), 4);

    // Budget stop at the third retire.
    cfg_start(1'b1, 1'b1, 11'd1024, 16'd3, 1'b0);
    tick(); drive(0, 0, 0, 0);
    tick(); drive(1, 0, 0, 0);
    check("t2_cause_clr", 32'(bus.stop_cause_o), 0);
    check("t2_iter_clr", 32'(bus.iter_cnt_o), 0);
    check("t2_icon_last", 32'(bus.fe_icon_last_raddr_plus_one_o), 1024);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(0, 1, 0, 0);
    check("t2_budget_allow", 32'(bus.issue_allow_o), 0);
    tick(); drive(0, 0, 0, 0);
    check("t2_drain_allow", 32'(bus.issue_allow_o), 0);
    check("t2_iter", 32'(bus.iter_cnt_o), 3);
    check("t2_cause", 32'(bus.stop_cause_o), 2);
    tick(); drive(0, 0, 0, 0);
    check("t2_done", 32'(bus.done_o), 1);
    tick();

    // Backpressure with flipping disabled, then abort with two in flight.
    cfg_start(1'b1, 1'b0, 11'd1024, 16'd0, 1'b1);
    tick();
    cfg_start(1'b0, 1'b1, 11'd0, 16'd0, 1'b0);
    check("t3_flip_dis", 32'(bus.fe_flip_disable_o), 1);
    check("t3_idle_busy", 32'(bus.busy_o), 0);
    tick(); drive(0, 0, 0, 0);
    tick(); drive(1, 0, 1, 0);
    check("t3_finish_ignored", 32'(bus.issue_allow_o), 1);
    tick(); drive(1, 0, 0, 0);
    check("t3_allow_1", 32'(bus.issue_allow_o), 1);
    tick(); drive(0, 0, 0, 0);
    check("t3_full_allow", 32'(bus.issue_allow_o), 0);
    tick(); drive(0, 1, 0, 0);
    check("t3_full_allow_r", 32'(bus.issue_allow_o), 0);
    tick(); drive(1, 0, 0, 0);
    check("t3_reopen", 32'(bus.issue_allow_o), 1);
    check("t3_iter", 32'(bus.iter_cnt_o), 1);
    tick(); drive(0, 0, 0, 1);
    check("t4_abort_allow", 32'(bus.issue_allow_o), 0);
    tick(); drive(0, 0, 0, 0);
    check("t4_drain_cmpt", 32'(bus.fe_cmpt_en_o), 0);
    check("t4_cause", 32'(bus.stop_cause_o), 3);
    tick(); drive(0, 1, 0, 0);
    check("t4_drain_busy", 32'(bus.busy_o), 1);
    tick(); drive(0, 1, 0, 0);
    check("t4_drain_cmpt2", 32'(bus.fe_cmpt_en_o), 0);
    tick(); drive(0, 0, 0, 0);
    check("t4_no_done_yet", 32'(bus.done_o), 0);
    tick(); drive(0, 0, 0, 0);
    check("t4_done", 32'(bus.done_o), 1);
    check("t4_iter", 32'(bus.iter_cnt_o), 3);
    tick();

    // Simultaneous abort, budget and icon finish; config write in RUN ignored.
    cfg_start(1'b1, 1'b1, 11'd8, 16'd2, 1'b0);
    tick(); drive(0, 0, 0, 0);
    tick(); drive(1, 0, 0, 0);
    tick(); drive(1, 1, 0, 0);
    bus.cfg_valid_i    = 1'b1;
    bus.cfg_icon_num_i = 11'd99;
    #1;
    check("t5_run_ready", 32'(bus.cfg_ready_o), 0);
    tick(); drive(0, 1, 1, 1);
    check("t5_allow", 32'(bus.issue_allow_o), 0);
    tick(); drive(0, 0, 0, 0);
    check("t5_cause", 32'(bus.stop_cause_o), 3);
    check("t5_icon_last", 32'(bus.fe_icon_last_raddr_plus_one_o), 8);
    tick(); drive(0, 0, 0, 0);
    check("t5_done", 32'(bus.done_o), 1);
    check("t5_iter", 32'(bus.iter_cnt_o), 2);
    tick();

    // Reset mid-run, then a run with the cleared config.
    cfg_start(1'b0, 1'b1, 11'd0, 16'd0, 1'b0);
    tick(); drive(0, 0, 0, 0);
    tick(); drive(1, 0, 0, 0);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(0, 0, 0, 0);
    check("t6_pre_iter", 32'(bus.iter_cnt_o), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(bus.busy_o), 0);
    check("t6_rst_ready", 32'(bus.cfg_ready_o), 1);
    check("t6_rst_fe_en", 32'(bus.fe_en_o), 0);
    check("t6_rst_cmpt", 32'(bus.fe_cmpt_en_o), 0);
    check("t6_rst_icon", 32'(bus.fe_icon_last_raddr_plus_one_o), 0);
    check("t6_rst_iter", 32'(bus.iter_cnt_o), 0);
    #1 rst = 1'b0;
    tick();
    cfg_start(1'b0, 1'b1, 11'd0, 16'd0, 1'b0);
    tick(); drive(0, 0, 0, 0);
    check("t6_flush", 32'(bus.fe_flush_o), 1);
    tick(); drive(1, 0, 0, 0);
    check("t6_allow", 32'(bus.issue_allow_o), 1);
    check("t6_icon_last", 32'(bus.fe_icon_last_raddr_plus_one_o), 0);
    tick(); drive(0, 1, 0, 0);
    tick(); drive(0, 0, 0, 1);
    check("t6_iter", 32'(bus.iter_cnt_o), 1);
    tick(); drive(0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0);
    check("t6_done", 32'(bus.done_o), 1);
    check("t6_cause", 32'(bus.stop_cause_o), 3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flip_scheduler.md
Name: flip_scheduler

Overview:
- Run-level controller for the flip engine. Accepts a per-run configuration, flushes the engine, then gates spin issue into it.
- Counts issued and retired spins and stops the run on the first of three events: flip-icon exhaustion, iteration budget reached, or abort. It then drains in-flight spins and signals completion.
- Sits between the annealing top-level control and the flip engine and icon memory.

Parameters:
- FLIP_ICON_DEPTH, 1024, number of flip-icon entries in icon memory
- ICON_ADDR_W, $clog2(FLIP_ICON_DEPTH)+1, icon address/count width; one extra bit so count == DEPTH is representable
- ITER_W, 16, iteration counter width
- MAX_INFLIGHT, 2, maximum spins issued but not yet retired

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- cfg_valid_i  in  1  configuration valid
- cfg_ready_o  out  1  configuration accepted; high only in IDLE
- cfg_icon_num_i  in  ICON_ADDR_W  number of icons for this run, 1..FLIP_ICON_DEPTH
- cfg_max_iter_i  in  ITER_W  iteration budget; 0 = unlimited
- cfg_flip_disable_i  in  1  bypass flipping for this run
- start_i  in  1  start pulse
- abort_i  in  1  request early stop
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- stop_cause_o  out  2  0 = none, 1 = icon finish, 2 = iteration budget, 3 = abort; held until next start
- iter_cnt_o  out  ITER_W  retired-spin count of current/last run
- fe_en_o  out  1  flip engine enable
- fe_cmpt_en_o  out  1  flip engine compute enable
- fe_flush_o  out  1  flip engine flush
- fe_flip_disable_o  out  1  registered cfg_flip_disable_i
- fe_icon_last_raddr_plus_one_o  out  ICON_ADDR_W  registered cfg_icon_num_i
- fe_icon_finish_i  in  1  flip engine icon finish indication
- issue_allow_o  out  1  upstream may present a spin to the flip engine
- spin_issue_i  in  1  flip engine input handshake occurred
- spin_retire_i  in  1  flip engine output handshake occurred

Behaviour:
- Reset values (rst_i asserted, async):
  - state = IDLE; all counters = 0; stop_cause_o = 0.
  - All fe_* outputs = 0, except that cfg registers also reset to 0.
  - busy_o = 0, done_o = 0, issue_allow_o = 0, cfg_ready_o = 1.
- Configuration:
  - Config registers load when cfg_valid_i & cfg_ready_o.
  - Writes are ignored outside IDLE.
  - Config persists across runs until rewritten.
- State machine: IDLE -> FLUSH -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE -> FLUSH: start_i. If start_i and cfg_valid_i coincide, config loads first and the run uses the new config. start_i outside IDLE is ignored.
  - FLUSH lasts exactly 1 cycle: fe_flush_o = 1, fe_en_o = 1. On exit, outstanding, iter_cnt_o and stop_cause_o clear to 0.
  - RUN: fe_en_o = 1, fe_cmpt_en_o = 1.
    - issue_allow_o = (outstanding < MAX_INFLIGHT) & no stop condition this cycle.
    - The stop condition is evaluated combinationally each RUN cycle. Priority when simultaneous: abort (3) > budget (2) > icon finish (1).
    - Icon finish: fe_icon_finish_i = 1 (suppressed when fe_flip_disable_o = 1).
    - Budget: cfg_max_iter != 0 and iter_cnt_o + spin_retire_i >= cfg_max_iter.
    - On stop: stop_cause_o is latched and the FSM moves to DRAIN.
  - DRAIN: fe_en_o = 1, fe_cmpt_en_o = 0, issue_allow_o = 0. Exit to DONE when outstanding == 0 and no retire this cycle; checked the first DRAIN cycle, so zero outstanding exits after 1 cycle.
  - DONE: 1 cycle, done_o = 1, fe_en_o = 0; then IDLE.
  - abort_i in FLUSH: stop_cause_o = 3 is latched and FLUSH completes, then DRAIN. abort_i in DRAIN/DONE/IDLE is ignored.
- Counters:
  - outstanding: width $clog2(MAX_INFLIGHT+1); +1 on spin_issue_i, −1 on spin_retire_i; both in the same cycle = unchanged.
  - Issue while outstanding == MAX_INFLIGHT, or retire while 0, is a protocol error: the counter saturates and a simulation assertion fires.
  - iter_cnt_o: +1 per spin_retire_i in RUN or DRAIN; saturates at all-ones; holds after DONE.
- Latency: start_i at cycle t -> issue_allow_o high at t+2, when outstanding = 0.

Test Plan:
- Icon exhaustion: cfg icon_num = 4, max_iter = 0, start -> issue 4 spins. Require:
  - fe_icon_last_raddr_plus_one_o = 4.
  - Stop on fe_icon_finish_i with stop_cause_o = 1.
  - done_o pulses one cycle after the last retire; iter_cnt_o = 4.
- Budget stop: max_iter = 3, icon_num = 1024, continuous retire -> issue_allow_o drops in the cycle of the 3rd retire; stop_cause_o = 2; iter_cnt_o = 3; no 4th issue.
- Backpressure: retire stalled, issue 2 spins -> issue_allow_o = 0 while outstanding = 2. One retire -> issue_allow_o = 1 next cycle.
- Abort mid-run with 2 outstanding -> DRAIN holds fe_cmpt_en_o = 0 until 2 retires; done_o after; stop_cause_o = 3.
- Simultaneous abort, budget hit and icon finish in one cycle -> stop_cause_o = 3. Config write during RUN is ignored and cfg_ready_o = 0.
- rst_i asserted mid-RUN -> all outputs return to reset values immediately without a clock edge; a following start runs normally with the old config cleared (icon_num = 0).
